mem_req_sched: RTL and testbench

- Sequences the data cache between two requesters: the load unit and the store-commit unit.
- Arbitrates between them round-robin and keeps one request outstanding.
- On a load miss, fetches the word from backing memory, writes it into the cache with an SW, then replays the load.
- Sits between the LSU/commit stage and the data cache; result writeback goes to the CDB/ROB.

---
 rtl/mem_req_sched.sv | 252 +++++++++++++++++++++++++
 tb/tb_mem_req_sched.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_sched.sv
// Data-cache request sequencer: round-robin load/store arbitration, one request
// in flight, load-miss refill from backing memory followed by a load replay.
module mem_req_sched #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned MAX_REPLAY  = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_pc,
  input  logic [31:0] ld_addr,
  input  logic [5:0]  ld_reg,
  input  logic [3:0]  ld_op,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_pc,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_op,
  output logic        c_read_en,
  output logic        c_write_en,
  output logic [31:0] c_pc,
  output logic [31:0] c_addr,
  output logic [5:0]  c_reg,
  output logic [3:0]  c_op,
  output logic [31:0] c_data,
  input  logic        c_data_valid,
  input  logic [31:0] c_lwdata,
  input  logic        c_has_stored,
  input  logic        c_miss,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        resp_valid,
  output logic [31:0] resp_pc,
  output logic [5:0]  resp_reg,
  output logic [31:0] resp_data,
  output logic        resp_is_store,
  output logic        busy,
  output logic        err
);

  localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned RW = $clog2(MAX_REPLAY + 2);
  localparam logic [3:0] OP_SW = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_MREQ, S_MWAIT, S_FILL, S_RESP
  } state_t;

  typedef struct packed {
    logic        is_store;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [5:0]  rg;
    logic [3:0]  op;
  } req_t;

  typedef struct packed {
    logic        read_en;
    logic        write_en;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [5:0]  rg;
    logic [3:0]  op;
    logic [31:0] data;
  } cbus_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [5:0]  rg;
    logic [31:0] data;
    logic        is_store;
  } resp_t;

  state_t      state, state_n;
  req_t        req_q, req_n;
  logic [31:0] data_q, data_n;
  logic [TW-1:0] tmo_q, tmo_n;
  logic [RW-1:0] rpl_q, rpl_n;
  logic        err_n;
  logic        last_st_q, last_st_n;
  cbus_t       cbus_q, cbus_n;
  resp_t       resp_q, resp_n;
  logic        mreq_valid_n;
  logic [31:0] mreq_addr_n;
  logic        busy_n;
  logic        grant_ld;
  logic [31:0] aligned_n;

  // Round-robin: with both sides valid, the side that did not win last time goes.
  assign grant_ld = ld_valid && (!st_valid || last_st_q);
  assign ld_ready = (state == S_IDLE) && grant_ld;
  assign st_ready = (state == S_IDLE) && st_valid && !grant_ld;

  // Next state, and next values of every registered output derived from it.
  always_comb begin
    state_n   = state;
    req_n     = req_q;
    data_n    = data_q;
    tmo_n     = tmo_q;
    rpl_n     = rpl_q;
    err_n     = err;
    last_st_n = last_st_q;

    unique case (state)
      S_IDLE: begin
        if (ld_valid && ld_ready) begin
          req_n     = '{is_store: 1'b0, pc: ld_pc, addr: ld_addr, data: 32'd0,
                        rg: ld_reg, op: ld_op};
          data_n    = 32'd0;
          last_st_n = 1'b0;
          state_n   = S_ISSUE;
        end else if (st_valid && st_ready) begin
          req_n     = '{is_store: 1'b1, pc: st_pc, addr: st_addr, data: st_data,
                        rg: 6'd0, op: st_op};
          data_n    = 32'd0;
          last_st_n = 1'b1;
          state_n   = S_ISSUE;
        end
      end
      S_ISSUE: state_n = S_WAIT;
      S_WAIT: begin
        if (req_q.is_store) begin
          if (c_has_stored) state_n = S_RESP;
        end else if (c_data_valid) begin
          data_n  = c_lwdata;
          state_n = S_RESP;
        end else if (c_miss) begin
          state_n = S_MREQ;
        end
      end
      S_MREQ: state_n = S_MWAIT;
      S_MWAIT: begin
        if (mem_resp_valid) begin
          data_n  = mem_resp_data;
          tmo_n   = '0;
          state_n = S_FILL;
        end else if (tmo_q == TW'(MEM_TIMEOUT - 1)) begin
          err_n   = 1'b1;
          data_n  = 32'd0;
          state_n = S_RESP;
        end else begin
          tmo_n = tmo_q + TW'(1);
        end
      end
      S_FILL: begin
        if (rpl_q == RW'(MAX_REPLAY)) begin
          err_n   = 1'b1;
          data_n  = 32'd0;
          state_n = S_RESP;
        end else begin
          rpl_n   = rpl_q + RW'(1);
          state_n = S_ISSUE;
        end
      end
      S_RESP: begin
        tmo_n   = '0;
        rpl_n   = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    aligned_n    = {req_n.addr[31:2], 2'b00};
    cbus_n       = '0;
    resp_n       = '0;
    mreq_valid_n = 1'b0;
    mreq_addr_n  = 32'd0;
    busy_n       = (state_n != S_IDLE);

    unique case (state_n)
      S_ISSUE: begin
        cbus_n.read_en  = !req_n.is_store;
        cbus_n.write_en = req_n.is_store;
        cbus_n.pc       = req_n.pc;
        cbus_n.addr     = req_n.addr;
        cbus_n.rg       = req_n.rg;
        cbus_n.op       = req_n.op;
        cbus_n.data     = req_n.data;
      end
      S_FILL: begin
        cbus_n.write_en = 1'b1;
        cbus_n.pc       = req_n.pc;
        cbus_n.addr     = aligned_n;
        cbus_n.rg       = req_n.rg;
        cbus_n.op       = OP_SW;
        cbus_n.data     = data_n;
      end
      S_MREQ: begin
        mreq_valid_n = 1'b1;
        mreq_addr_n  = aligned_n;
      end
      S_RESP: begin
        resp_n.valid    = 1'b1;
        resp_n.pc       = req_n.pc;
        resp_n.rg       = req_n.rg;
        resp_n.data     = data_n;
        resp_n.is_store = req_n.is_store;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= S_IDLE;
      req_q         <= '0;
      data_q        <= 32'd0;
      tmo_q         <= '0;
      rpl_q         <= '0;
      err           <= 1'b0;
      last_st_q     <= 1'b1;
      cbus_q        <= '0;
      resp_q        <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= 32'd0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      req_q         <= req_n;
      data_q        <= data_n;
      tmo_q         <= tmo_n;
      rpl_q         <= rpl_n;
      err           <= err_n;
      last_st_q     <= last_st_n;
      cbus_q        <= cbus_n;
      resp_q        <= resp_n;
      mem_req_valid <= mreq_valid_n;
      mem_req_addr  <= mreq_addr_n;
      busy          <= busy_n;
    end
  end

  assign c_read_en     = cbus_q.read_en;
  assign c_write_en    = cbus_q.write_en;
  assign c_pc          = cbus_q.pc;
  assign c_addr        = cbus_q.addr;
  assign c_reg         = cbus_q.rg;
  assign c_op          = cbus_q.op;
  assign c_data        = cbus_q.data;
  assign resp_valid    = resp_q.valid;
  assign resp_pc       = resp_q.pc;
  assign resp_reg      = resp_q.rg;
  assign resp_data     = resp_q.data;
  assign resp_is_store = resp_q.is_store;

endmodule

// File: tb/tb_mem_req_sched.sv
// Randomized scoreboard bench for mem_req_sched with behavioural cache and
// backing-memory models and a transaction-level reference model.
module tb_mem_req_sched;

  localparam int MEM_TIMEOUT = 64;
  localparam int MAX_REPLAY  = 2;

  logic        clk, rstn;
  logic        ld_valid, ld_ready, st_valid, st_ready;
  logic [31:0] ld_pc, ld_addr, st_pc, st_addr, st_data;
  logic [5:0]  ld_reg;
  logic [3:0]  ld_op, st_op;
  logic        c_read_en, c_write_en;
  logic [31:0] c_pc, c_addr, c_data;
  logic [5:0]  c_reg;
  logic [3:0]  c_op;
  logic        c_data_valid, c_has_stored, c_miss;
  logic [31:0] c_lwdata;
  logic        mem_req_valid, mem_resp_valid;
  logic [31:0] mem_req_addr, mem_resp_data;
  logic        resp_valid, resp_is_store, busy, err;
  logic [31:0] resp_pc, resp_data;
  logic [5:0]  resp_reg;

  mem_req_sched #(.MEM_TIMEOUT(MEM_TIMEOUT), .MAX_REPLAY(MAX_REPLAY)) dut (
    .clk(clk), .rstn(rstn),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_pc(ld_pc), .ld_addr(ld_addr),
    .ld_reg(ld_reg), .ld_op(ld_op),
    .st_valid(st_valid), .st_ready(st_ready), .st_pc(st_pc), .st_addr(st_addr),
    .st_data(st_data), .st_op(st_op),
    .c_read_en(c_read_en), .c_write_en(c_write_en), .c_pc(c_pc), .c_addr(c_addr),
    .c_reg(c_reg), .c_op(c_op), .c_data(c_data),
    .c_data_valid(c_data_valid), .c_lwdata(c_lwdata), .c_has_stored(c_has_stored),
    .c_miss(c_miss),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .resp_valid(resp_valid), .resp_pc(resp_pc), .resp_reg(resp_reg),
    .resp_data(resp_data), .resp_is_store(resp_is_store), .busy(busy), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          is_st;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [5:0]  rg;
    logic [3:0]  op;
    int          misses;
    bit          tmo;
    int          lat;
  } tb_req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic [5:0]  rg;
    bit          is_st;
    bit          err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t    exp_q[$];
  tb_req_t cur;
  bit      done;
  bit      model_last_ld;
  bit      sticky_err;
  int      cyc = 0;
  int      n_chk = 0;
  int      n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] al;
    al = align(a);
    if (al == 32'h300) return 32'hAABBCCDD;
    if (al == 32'h100) return 32'hDEADBEEF;
    return (al * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // The cache's own load extraction: LW whole word, LB big-endian byte, zero-extended.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [31:0] a,
                                          input logic [3:0] op);
    int sh;
    if (op != 4'd7) return w;
    sh = 3 - int'(a[1:0]);
    return {24'd0, 8'(w >> (8 * sh))};
  endfunction

  function automatic tb_req_t mk(input bit is_st, input logic [31:0] pc, addr, data,
                                 input logic [5:0] rg, input logic [3:0] op,
                                 input int misses, input bit tmo, input int lat);
    tb_req_t r;
    r.is_st = is_st; r.pc = pc; r.addr = addr; r.data = data; r.rg = rg;
    r.op = op; r.misses = misses; r.tmo = tmo; r.lat = lat;
    return r;
  endfunction

  // Reference model: completion of one request from its plan of cache/memory behaviour.
  function automatic exp_t model(input tb_req_t r, input int acc);
    exp_t e;
    e.pc = r.pc; e.acc = acc; e.is_st = r.is_st; e.rg = r.is_st ? 6'd0 : r.rg;
    e.data = 32'd0; e.err = 1'b0; e.lat = -1;
    if (r.is_st) e.lat = 3;
    else if (r.misses == 0) begin
      e.data = extract(mem_word(r.addr), r.addr, r.op);
      e.lat  = 3;
    end else if (r.tmo) begin
      e.err = 1'b1;
      e.lat = 4 + MEM_TIMEOUT;
    end else if (r.misses > MAX_REPLAY) e.err = 1'b1;
    else e.data = extract(mem_word(r.addr), r.addr, r.op);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
  endtask

  // Cache model: responds one cycle after each strobe; misses the first N reads.
  initial begin
    bit rd, wr, st_txn;
    logic [31:0] a;
    logic [3:0]  op;
    int rd_cnt;
    c_data_valid = 1'b0; c_has_stored = 1'b0; c_miss = 1'b0; c_lwdata = 32'd0;
    rd_cnt = 0; rd = 1'b0; wr = 1'b0; st_txn = 1'b0; a = 32'd0; op = 4'd0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        rd_cnt = 0; rd = 1'b0; wr = 1'b0;
      end else begin
        rd = c_read_en; wr = c_write_en; a = c_addr; op = c_op; st_txn = cur.is_st;
        if (resp_valid) rd_cnt = 0;
      end
      @(posedge clk);
      #1;
      c_data_valid = 1'b0; c_has_stored = 1'b0; c_miss = 1'b0;
      c_lwdata = 32'($urandom);
      if (rd) begin
        if (rd_cnt < cur.misses) c_miss = 1'b1;
        else begin
          c_data_valid = 1'b1;
          c_lwdata = extract(mem_word(a), a, op);
        end
        rd_cnt++;
      end
      if (wr) begin
        c_has_stored = 1'b1;
        if (st_txn) c_miss = 1'($urandom_range(0, 1));
      end
    end
  end

  // Backing memory: answers a refill after the planned latency, or never on timeout.
  initial begin
    logic [31:0] a;
    int lat;
    mem_resp_valid = 1'b0; mem_resp_data = 32'd0;
    forever begin
      @(negedge clk);
      if (rstn && mem_req_valid && !cur.tmo) begin
        a = mem_req_addr;
        lat = cur.lat;
        repeat (lat) @(posedge clk);
        #1;
        mem_resp_valid = 1'b1;
        mem_resp_data = mem_word(a);
        @(posedge clk);
        #1;
        mem_resp_valid = 1'b0;
        mem_resp_data = 32'($urandom);
      end
    end
  end

  // Monitor: all comparisons, sampled on the falling edge.
  initial begin
    exp_t e;
    int wr_pulses;
    wr_pulses = 0;
    forever begin
      @(negedge clk);
      if (done) begin
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
      end
      if (!rstn) begin
        chk("reset_outs", 32'(|{c_read_en, c_write_en, c_pc, c_addr, c_reg, c_op, c_data,
                                mem_req_valid, mem_req_addr, resp_valid, resp_pc,
                                resp_reg, resp_data, resp_is_store, err}), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        wr_pulses = 0;
        continue;
      end
      if (c_read_en) begin
        chk("rd_addr", c_addr, cur.addr);
        chk("rd_op", 32'(c_op), 32'(cur.op));
        chk("rd_reg", 32'(c_reg), 32'(cur.rg));
      end
      if (c_write_en) begin
        if (cur.is_st) begin
          wr_pulses++;
          chk("st_addr", c_addr, cur.addr);
          chk("st_data", c_data, cur.data);
        end else begin
          chk("fill_addr", c_addr, align(cur.addr));
          chk("fill_op", 32'(c_op), 32'd10);
          chk("fill_data", c_data, mem_word(cur.addr));
        end
      end
      if (mem_req_valid) chk("mem_addr", mem_req_addr, align(cur.addr));
      if (resp_valid) begin
        if (exp_q.size() == 0) chk("spurious_resp", 32'(resp_valid), 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("resp_pc", resp_pc, e.pc);
          chk("resp_reg", 32'(resp_reg), 32'(e.rg));
          chk("resp_data", resp_data, e.data);
          chk("resp_is_store", 32'(resp_is_store), 32'(e.is_st));
          chk("resp_err", 32'(err), 32'(e.err));
          if (e.lat >= 0) chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          if (e.is_st) chk("st_pulses", 32'(wr_pulses), 32'd1);
        end
        wr_pulses = 0;
      end
    end
  end

  // Present up to one load and one store; the model predicts who wins each transfer.
  task automatic offer(input bit use_ld, input tb_req_t lr, input bit use_st, input tb_req_t sr);
    bit pl, ps, lx, sx, pick_st;
    int guard;
    exp_t e;
    pl = use_ld; ps = use_st; guard = 0;
    if (pl) begin
      ld_valid = 1'b1; ld_pc = lr.pc; ld_addr = lr.addr; ld_reg = lr.rg; ld_op = lr.op;
    end
    if (ps) begin
      st_valid = 1'b1; st_pc = sr.pc; st_addr = sr.addr; st_data = sr.data; st_op = sr.op;
    end
    while (pl || ps) begin
      @(negedge clk);
      lx = pl && ld_ready;
      sx = ps && st_ready;
      if (lx || sx) begin
        pick_st = (pl && ps) ? model_last_ld : ps;
        model_last_ld = !pick_st;
        e = model(pick_st ? sr : lr, cyc);
        sticky_err = sticky_err | e.err;
        e.err = sticky_err;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cur = lx ? lr : sr;
        if (lx) begin pl = 1'b0; ld_valid = 1'b0; end
        else begin ps = 1'b0; st_valid = 1'b0; end
        guard = 0;
      end else begin
        guard++;
        if (guard > 400) begin
          $display("FAIL accept_timeout: no ready within %0d cycles", guard);
          $fatal(1);
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk);
      guard++;
      if (guard > 2000) begin
        $display("FAIL drain_timeout: %0d responses outstanding", exp_q.size());
        $fatal(1);
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rstn = 1'b0; ld_valid = 1'b0; st_valid = 1'b0;
    exp_q.delete();
    sticky_err = 1'b0; model_last_ld = 1'b0;
    cur = mk(1'b0, 32'd0, 32'd0, 32'd0, 6'd0, 4'd0, 0, 1'b0, 1);
    repeat (n) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  function automatic tb_req_t rand_ld();
    int m, pick;
    pick = $urandom_range(0, 9);
    m = (pick < 6) ? 0 : (pick < 8) ? 1 : (pick < 9) ? 2 : 3;
    return mk(1'b0, 32'($urandom), 32'($urandom_range(0, 32'hFFF)), 32'd0,
              6'($urandom_range(1, 63)), ($urandom_range(0, 1) == 1) ? 4'd7 : 4'd8,
              m, (m > 0) && ($urandom_range(0, 19) == 0), $urandom_range(1, 6));
  endfunction

  function automatic tb_req_t rand_st();
    return mk(1'b1, 32'($urandom), 32'($urandom_range(0, 32'hFFF)), 32'($urandom), 6'd0,
              ($urandom_range(0, 1) == 1) ? 4'd9 : 4'd10, 0, 1'b0, 1);
  endfunction

  initial begin
    tb_req_t l1, s1, none;
    int guard;
    bit ul, us;
    done = 1'b0; rstn = 1'b0; ld_valid = 1'b0; st_valid = 1'b0;
    ld_pc = 32'd0; ld_addr = 32'd0; ld_reg = 6'd0; ld_op = 4'd0;
    st_pc = 32'd0; st_addr = 32'd0; st_data = 32'd0; st_op = 4'd0;
    sticky_err = 1'b0; model_last_ld = 1'b0;
    none = mk(1'b0, 32'd0, 32'd0, 32'd0, 6'd0, 4'd0, 0, 1'b0, 1);
    cur = none;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Contention with hit loads and plain stores: load, store, load, store.
    l1 = mk(1'b0, 32'h1000, 32'h100, 32'd0, 6'd5, 4'd8, 0, 1'b0, 1);
    s1 = mk(1'b1, 32'h2000, 32'h200, 32'h12345678, 6'd0, 4'd10, 0, 1'b0, 1);
    offer(1'b1, l1, 1'b1, s1);
    l1.pc = 32'h1004; s1.pc = 32'h2004;
    offer(1'b1, l1, 1'b1, s1);

    offer(1'b1, mk(1'b0, 32'h3000, 32'h303, 32'd0, 6'd7, 4'd7, 1, 1'b0, 5), 1'b0, none);
    offer(1'b1, mk(1'b0, 32'h4000, 32'h400, 32'd0, 6'd9, 4'd8, 1, 1'b1, 1), 1'b0, none);
    drain();

    // Reset while waiting for refill data; the late response must be ignored.
    offer(1'b1, mk(1'b0, 32'h5000, 32'h504, 32'd0, 6'd11, 4'd8, 1, 1'b0, 12), 1'b0, none);
    guard = 0;
    while (!mem_req_valid && guard < 50) begin @(negedge clk); guard++; end
    repeat (3) @(posedge clk);
    do_reset(1);
    repeat (20) @(posedge clk);
    #1;

    for (int i = 0; i < 60; i++) begin
      ul = ($urandom_range(0, 3) != 0);
      us = ($urandom_range(0, 2) != 0) || !ul;
      offer(ul, rand_ld(), us, rand_st());
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
    end
    drain();
    done = 1'b1;
  end

endmodule
